// File: rtl/uart_pkg.sv
// Shared UART definitions: line state encoding and counter sizing helpers.
// Imported by the transmitter, its bit timer and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Width for a counter holding 0..n-1 (never zero bits).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Held at zero while restart is high.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int W = cnt_w(CLKS_PER_BIT);

    logic [W-1:0] r_count;

    assign tick = (r_count == W'(CLKS_PER_BIT - 1));

    // Count cycles within a bit, reloading to zero at the bit end.
    always_ff @(posedge clk) begin
        if (reset || restart || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with a one-entry holding register and timed BREAK.
// Frames are LSB first; a held byte follows the stop bit with no gap.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int BREAK_BITS   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    input  logic                    uart_tx_break,
    output logic                    uart_tx_ready,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BIT_RATE);
    localparam int IDX_W = cnt_w(BREAK_BITS);

    tx_state_t               r_state;
    tx_state_t               w_state_next;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_next;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [PAYLOAD_BITS-1:0] w_shift_next;
    logic [PAYLOAD_BITS-1:0] r_hold;
    logic                    r_hold_full;
    logic                    r_brk_pend;
    logic                    r_txd;
    logic                    w_txd_next;
    logic                    w_tick;
    logic                    w_load;
    logic                    w_brk_enter;
    logic                    w_accept;

    assign w_accept      = uart_tx_en && !r_hold_full;
    assign uart_tx_ready = !r_hold_full;
    assign uart_tx_busy  = (r_state != IDLE) || r_hold_full;
    assign uart_txd      = r_txd;

    uart_bit_timer #(
        .CLKS_PER_BIT(CPB)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(r_state == IDLE),
        .tick   (w_tick)
    );

    // State register plus the shifter, bit index and registered line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_txd   <= w_txd_next;
        end
    end

    // Holding register and sticky break request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_brk_pend  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= uart_tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            r_brk_pend <= (r_brk_pend && !w_brk_enter) || uart_tx_break;
        end
    end

    // Next state: held data always wins over a pending break.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_state_next = START;
                end else if (r_brk_pend) begin
                    w_state_next = BREAK;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick && r_idx == IDX_W'(PAYLOAD_BITS - 1)) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_tick && r_idx == IDX_W'(STOP_BITS - 1)) begin
                    if (r_hold_full) begin
                        w_state_next = START;
                    end else if (r_brk_pend) begin
                        w_state_next = BREAK;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            BREAK: begin
                if (w_tick && r_idx == IDX_W'(BREAK_BITS - 1)) begin
                    w_state_next = STOP;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath controls and the next line level, decoded from next state.
    always_comb begin
        w_load      = (w_state_next == START) && (r_state != START);
        w_brk_enter = (w_state_next == BREAK) && (r_state != BREAK);

        if (w_state_next != r_state) begin
            w_idx_next = '0;
        end else if (w_tick) begin
            w_idx_next = r_idx + 1'b1;
        end else begin
            w_idx_next = r_idx;
        end

        if (w_load) begin
            w_shift_next = r_hold;
        end else if (r_state == DATA && w_tick) begin
            w_shift_next = r_shift >> 1;
        end else begin
            w_shift_next = r_shift;
        end

        unique case (w_state_next)
            START, BREAK: w_txd_next = 1'b0;
            DATA:         w_txd_next = w_shift_next[0];
            default:      w_txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// cycle by cycle against a queue-based model of the expected line.
module tb_uart_tx_buffered;

    localparam int CLK_HZ   = 1000000;
    localparam int BIT_RATE = 100000;
    localparam int PB       = 8;
    localparam int SB       = 1;
    localparam int BB       = 12;
    localparam int CPB      = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [PB-1:0] data;
    logic          brk;
    logic          ready;
    logic          busy;
    logic          txd;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: every future line cycle queued, plus holding slot and break flag.
    bit            q_line[$];
    logic          m_hold_full;
    logic [PB-1:0] m_hold;
    logic          m_pend;
    logic          m_txd;
    logic          m_busy;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(PB),
        .STOP_BITS   (SB),
        .BREAK_BITS  (BB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_tx_en   (en),
        .uart_tx_data (data),
        .uart_tx_break(brk),
        .uart_tx_ready(ready),
        .uart_tx_busy (busy),
        .uart_txd     (txd)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic push_bits(input bit v, input int n);
        for (int i = 0; i < n; i++) q_line.push_back(v);
    endtask

    task automatic push_frame(input logic [PB-1:0] d);
        push_bits(1'b0, CPB);
        for (int b = 0; b < PB; b++) push_bits(d[b], CPB);
        push_bits(1'b1, SB * CPB);
    endtask

    // One clock edge of the model, using the inputs seen at that edge.
    task automatic model_edge();
        bit hf;
        bit pd;
        bit active;
        if (reset) begin
            q_line.delete();
            m_hold_full = 1'b0;
            m_pend      = 1'b0;
            m_txd       = 1'b1;
            m_busy      = 1'b0;
            return;
        end
        hf = m_hold_full;
        pd = m_pend;
        if (q_line.size() == 0) begin
            if (hf) begin
                push_frame(m_hold);
                m_hold_full = 1'b0;
            end else if (pd) begin
                push_bits(1'b0, BB * CPB);
                push_bits(1'b1, SB * CPB);
                m_pend = 1'b0;
            end
        end
        if (en && !hf) begin
            m_hold      = data;
            m_hold_full = 1'b1;
        end
        if (brk) m_pend = 1'b1;
        active = (q_line.size() != 0);
        m_txd  = active ? q_line.pop_front() : 1'b1;
        m_busy = active || m_hold_full;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("txd", 32'(txd), 32'(m_txd));
        check("ready", 32'(ready), 32'(!m_hold_full));
        check("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [PB-1:0] d);
        en   = 1'b1;
        data = d;
        step();
        en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        brk   = 1'b0;
        data  = '0;
        run(3);
        reset = 1'b0;

        // Quiet line after reset.
        run(200);

        // Single frame.
        send(8'hA5);
        run(110);

        // Back-to-back frames; the third write is dropped.
        send(8'h55);
        step();
        send(8'h0F);
        send(8'h77);
        run(220);

        // Break from idle.
        brk = 1'b1;
        step();
        brk = 1'b0;
        run(140);

        // Data and break together: frame first, then break.
        en   = 1'b1;
        brk  = 1'b1;
        data = 8'h3C;
        step();
        en   = 1'b0;
        brk  = 1'b0;
        run(240);

        // Reset inside data bit 3 with a byte held.
        send(8'hFF);
        step();
        send(8'h11);
        run(42);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(150);

        // Random traffic, breaks and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            en    = ($urandom_range(0, 7) == 0);
            data  = PB'($urandom);
            brk   = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 1999) == 0);
            step();
        end
        en    = 1'b0;
        brk   = 1'b0;
        reset = 1'b0;
        run(400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
UART transmitter with a one-entry holding register and BREAK generation. It is the transmit-side counterpart to the team's break-detecting UART receiver.
- Serialises PAYLOAD_BITS data frames (8N1 style, LSB first) onto uart_txd.
- Accepts a new byte while the previous frame is still shifting, so back-to-back echo traffic has no idle gap.
- Drives a timed BREAK (line held low) on request.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BIT_RATE, 9600, line bit rate in bits/s; CLKS_PER_BIT = CLK_HZ/BIT_RATE (integer divide), must be >= 2
PAYLOAD_BITS, 8, data bits per frame
STOP_BITS, 1, stop bits per frame (1 or 2)
BREAK_BITS, 16, BREAK length in bit times (must be > 1+PAYLOAD_BITS+STOP_BITS)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
uart_tx_en  input  1  write strobe; byte accepted on an edge where uart_tx_en && uart_tx_ready
uart_tx_data  input  PAYLOAD_BITS  byte to send, sampled on accept
uart_tx_break  input  1  BREAK request, single-cycle or level
uart_tx_ready  output  1  holding register empty
uart_tx_busy  output  1  frame/break in progress or byte pending
uart_txd  output  1  serial line, idle high, registered

Behaviour:
- Outputs decode from registered state only; no input-to-output combinational path.
- Reset (synchronous): uart_txd=1, state=IDLE, hold_full=0, bit counter=0, timer=0. Therefore uart_tx_ready=1 and uart_tx_busy=0.
- Reset mid-frame: uart_txd=1 from the next edge; the pending byte is discarded; the frame is truncated.
- Signal definitions: uart_tx_ready = !hold_full. uart_tx_busy = (state!=IDLE) || hold_full.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- Bit timer counts 0..CLKS_PER_BIT-1. The bit-end tick is the cycle where timer==CLKS_PER_BIT-1.
- Accept at edge N:
  - The holding register loads at edge N.
  - If state is IDLE, at edge N+1 the holding register transfers to the shifter, hold_full clears, state becomes START and uart_txd goes 0.
- Each bit occupies exactly CLKS_PER_BIT cycles.
- One frame is (1+PAYLOAD_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
- START: drive 0; at the tick go to DATA with bit index 0.
- DATA: drive shifter bit index (LSB first). At the tick, index PAYLOAD_BITS-1 goes to STOP; otherwise the index increments.
- STOP: drive 1 for STOP_BITS bit times. At the final tick:
  - if hold_full: transfer and go directly to START (no idle cycle);
  - else if a break is pending: go to BREAK;
  - else go to IDLE.
- Holding register while busy: writes accepted whenever uart_tx_ready=1, including during START/DATA/STOP/BREAK. Writes while uart_tx_ready=0 are ignored; the data is lost and no error is flagged.
- BREAK request handling:
  - Captured into a break_pending flag on any cycle uart_tx_break=1.
  - Acted on only from IDLE with hold_full=0, or at the end of STOP with hold_full=0.
  - If uart_tx_en and uart_tx_break are both high on the same IDLE edge: the data is accepted and sent first, then the break follows.
- BREAK state: drive 0 for BREAK_BITS*CLKS_PER_BIT cycles and clear break_pending on entry. Then go to STOP (mark-after-break, STOP_BITS bit times), then IDLE or the next frame.
- Bit index and timer widths: $clog2 of their ranges; they wrap only via explicit reload.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, STOP, BREAK);
  - a clks_per_bit(CLK_HZ, BIT_RATE) constant function;
  - the counter-width helpers.
  - The receiver reuses the same package.
- One natural sub-module, uart_bit_timer:
  - inputs: clk, reset, restart;
  - output: a single-cycle bit-end tick, parameterised by CLKS_PER_BIT.
- The FSM, holding register and shifter stay in the top block.

Test Plan:
All scenarios use CLK_HZ=1000000, BIT_RATE=100000 (CLKS_PER_BIT=10), PAYLOAD_BITS=8, STOP_BITS=1, BREAK_BITS=12.
- Reset, then 200 idle cycles -> uart_txd=1, uart_tx_ready=1, uart_tx_busy=0 throughout.
- Accept 0xA5 at edge N -> uart_txd=0 from N+1 for 10 cycles, then bits 1,0,1,0,0,1,0,1 (10 cycles each), stop high 10 cycles. uart_tx_busy falls after edge N+100.
- Write 0x55, then write 0x0F as soon as uart_tx_ready rises -> the second start bit immediately follows the first stop bit (no gap). uart_tx_ready=0 while 0x0F is held. A third write while not ready is dropped.
- Pulse uart_tx_break in IDLE -> uart_txd=0 for exactly 120 cycles, then high for 10 cycles, then IDLE with uart_tx_busy=0.
- Same-cycle uart_tx_en(0x3C) and uart_tx_break in IDLE -> the 0x3C frame (100 cycles), then a 120-cycle low, then a 10-cycle mark.
- Assert reset during DATA bit 3 of 0xFF with 0x11 held -> uart_txd=1 next cycle, busy=0, ready=1; 0x11 is never transmitted.
